// File: rtl/csr_trap_unit_if.sv
// CSR access, trap and redirect signals between the write-back stage and the CSR/trap unit.
interface csr_trap_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            stall_i;
  logic            re_i;
  logic [11:0]     raddr_i;
  logic [XLEN-1:0] rdata_o;
  logic            we_i;
  logic [11:0]     waddr_i;
  logic [1:0]      wop_i;
  logic [XLEN-1:0] wdata_i;
  logic            illegal_o;
  logic            ecall_i;
  logic            mret_i;
  logic [XLEN-1:0] pc_i;
  logic            instret_i;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  // Pipeline side drives requests and consumes read data / redirects.
  modport master (
    output stall_i, re_i, raddr_i, we_i, waddr_i, wop_i, wdata_i,
           ecall_i, mret_i, pc_i, instret_i,
    input  rdata_o, illegal_o, redirect_o, redirect_pc_o
  );

  // CSR/trap unit side.
  modport slave (
    input  stall_i, re_i, raddr_i, we_i, waddr_i, wop_i, wdata_i,
           ecall_i, mret_i, pc_i, instret_i,
    output rdata_o, illegal_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ecall/mret trap sequencing and cycle/instret counters.
module csr_trap_unit #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     HART_ID   = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input logic           clk,
  input logic           rst,
  csr_trap_unit_if.slave bus
);

  localparam int unsigned ADDR_W = 12;

  localparam logic [ADDR_W-1:0] A_MSTATUS  = 12'h300;
  localparam logic [ADDR_W-1:0] A_MISA     = 12'h301;
  localparam logic [ADDR_W-1:0] A_MIE      = 12'h304;
  localparam logic [ADDR_W-1:0] A_MTVEC    = 12'h305;
  localparam logic [ADDR_W-1:0] A_MSCRATCH = 12'h340;
  localparam logic [ADDR_W-1:0] A_MEPC     = 12'h341;
  localparam logic [ADDR_W-1:0] A_MCAUSE   = 12'h342;
  localparam logic [ADDR_W-1:0] A_MTVAL    = 12'h343;
  localparam logic [ADDR_W-1:0] A_MIP      = 12'h344;
  localparam logic [ADDR_W-1:0] A_MCYCLE   = 12'hB00;
  localparam logic [ADDR_W-1:0] A_MINSTRET = 12'hB02;
  localparam logic [ADDR_W-1:0] A_MHARTID  = 12'hF14;

  localparam logic [1:0]      MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL  = {MXL, {(XLEN-2){1'b0}}} | XLEN'(12'h100);
  localparam logic [XLEN-1:0] ALL_ONES  = '1;
  localparam logic [XLEN-1:0] ALIGN4    = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MSTAT_WR  = XLEN'(12'h088);
  localparam logic [XLEN-1:0] MIE_WR    = XLEN'(12'h888);

  logic            mstat_mie_q, mstat_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN:0]   rd_hit_val, wr_hit_val;
  logic [XLEN-1:0] wnew, wmask, wval;
  logic            wr_ro_range, wr_en, take_ecall, take_mret;

  assign mstatus_val = XLEN'({2'b11, 3'b000, mstat_mpie_q, 3'b000, mstat_mie_q, 3'b000});

  // Address decode: returns {implemented, current read value}.
  function automatic logic [XLEN:0] lookup(input logic [ADDR_W-1:0] a);
    logic [XLEN:0] r;
    r = {1'b1, {XLEN{1'b0}}};
    case (a)
      A_MSTATUS:  r[XLEN-1:0] = mstatus_val;
      A_MISA:     r[XLEN-1:0] = MISA_VAL;
      A_MIE:      r[XLEN-1:0] = mie_q;
      A_MTVEC:    r[XLEN-1:0] = mtvec_q;
      A_MSCRATCH: r[XLEN-1:0] = mscratch_q;
      A_MEPC:     r[XLEN-1:0] = mepc_q;
      A_MCAUSE:   r[XLEN-1:0] = mcause_q;
      A_MTVAL:    r[XLEN-1:0] = mtval_q;
      A_MIP:      r[XLEN-1:0] = '0;
      A_MCYCLE:   r[XLEN-1:0] = mcycle_q;
      A_MINSTRET: r[XLEN-1:0] = minstret_q;
      A_MHARTID:  r[XLEN-1:0] = XLEN'(HART_ID);
      12'hF11, 12'hF12, 12'hF13, 12'hF15: r[XLEN-1:0] = '0;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Read port and illegal-access detection.
  always_comb begin
    rd_hit_val  = lookup(bus.raddr_i);
    wr_hit_val  = lookup(bus.waddr_i);
    wr_ro_range = (bus.waddr_i[11:4] == 8'hF1);
  end

  assign bus.rdata_o   = bus.re_i ? rd_hit_val[XLEN-1:0] : '0;
  assign bus.illegal_o = (bus.re_i && !rd_hit_val[XLEN]) ||
                         (bus.we_i && (!wr_hit_val[XLEN] || wr_ro_range));

  // Read-modify-write value, masked to the writable bits of the target CSR.
  always_comb begin
    wnew  = wr_hit_val[XLEN-1:0];
    wmask = '0;
    case (bus.wop_i)
      2'b00:   wnew = bus.wdata_i;
      2'b01:   wnew = wr_hit_val[XLEN-1:0] | bus.wdata_i;
      2'b10:   wnew = wr_hit_val[XLEN-1:0] & ~bus.wdata_i;
      default: wnew = wr_hit_val[XLEN-1:0];
    endcase
    case (bus.waddr_i)
      A_MSTATUS:  wmask = MSTAT_WR;
      A_MIE:      wmask = MIE_WR;
      A_MTVEC:    wmask = ALIGN4;
      A_MEPC:     wmask = ALIGN4;
      A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MCYCLE, A_MINSTRET: wmask = ALL_ONES;
      default:    wmask = '0;
    endcase
    wval       = wnew & wmask;
    take_ecall = !bus.stall_i && bus.ecall_i;
    take_mret  = !bus.stall_i && !bus.ecall_i && bus.mret_i;
    wr_en      = bus.we_i && (bus.wop_i != 2'b11) && wr_hit_val[XLEN] && !wr_ro_range &&
                 !bus.stall_i && !bus.ecall_i && !bus.mret_i;
  end

  // CSR state, counters and registered redirect; later assignments override counter increments.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstat_mie_q   <= 1'b0;
      mstat_mpie_q  <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RST & ALIGN4;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mcycle_q   <= mcycle_q + XLEN'(1);
      redirect_q <= 1'b0;
      if (!bus.stall_i && bus.instret_i) minstret_q <= minstret_q + XLEN'(1);
      if (take_ecall) begin
        mepc_q        <= bus.pc_i & ALIGN4;
        mcause_q      <= XLEN'(11);
        mtval_q       <= '0;
        mstat_mpie_q  <= mstat_mie_q;
        mstat_mie_q   <= 1'b0;
        redirect_q    <= 1'b1;
        redirect_pc_q <= mtvec_q;
      end else if (take_mret) begin
        mstat_mie_q   <= mstat_mpie_q;
        mstat_mpie_q  <= 1'b1;
        redirect_q    <= 1'b1;
        redirect_pc_q <= mepc_q;
      end else if (wr_en) begin
        case (bus.waddr_i)
          A_MSTATUS: begin
            mstat_mie_q  <= wval[3];
            mstat_mpie_q <= wval[7];
          end
          A_MIE:      mie_q      <= wval;
          A_MTVEC:    mtvec_q    <= wval;
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval;
          A_MCAUSE:   mcause_q   <= wval;
          A_MTVAL:    mtval_q    <= wval;
          A_MCYCLE:   mcycle_q   <= wval;
          A_MINSTRET: minstret_q <= wval;
          default: ;
        endcase
      end
    end
  end

  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Randomised bench for csr_trap_unit checked against a table-driven CSR model.
module tb_csr_trap_unit;

  localparam int unsigned XL  = 64;
  localparam int unsigned HID = 3;
  localparam logic [63:0] MTV = 64'h8000_0000;
  localparam logic [63:0] MISA_EXP = 64'h8000_0000_0000_0100;

  logic clk, rst;
  csr_trap_unit_if #(.XLEN(XL)) bus ();

  csr_trap_unit #(.XLEN(XL), .HART_ID(HID), .MTVEC_RST(MTV)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endfunction

  // Model: CSR contents and writable-bit masks keyed by address.
  logic [63:0] m_csr   [logic [11:0]];
  logic [63:0] m_wmask [logic [11:0]];
  logic        m_valid = 1'b0;
  logic        e_redir;
  logic [63:0] e_rpc;

  function automatic void m_reset();
    m_csr.delete();
    m_wmask.delete();
    m_csr[12'h300] = 0; m_wmask[12'h300] = 64'h88;
    m_csr[12'h301] = 0; m_wmask[12'h301] = 0;
    m_csr[12'h304] = 0; m_wmask[12'h304] = 64'h888;
    m_csr[12'h305] = MTV & ~64'h3; m_wmask[12'h305] = ~64'h3;
    m_csr[12'h340] = 0; m_wmask[12'h340] = '1;
    m_csr[12'h341] = 0; m_wmask[12'h341] = ~64'h3;
    m_csr[12'h342] = 0; m_wmask[12'h342] = '1;
    m_csr[12'h343] = 0; m_wmask[12'h343] = '1;
    m_csr[12'h344] = 0; m_wmask[12'h344] = 0;
    m_csr[12'hB00] = 0; m_wmask[12'hB00] = '1;
    m_csr[12'hB02] = 0; m_wmask[12'hB02] = '1;
    for (int a = 12'hF11; a <= 12'hF15; a++) begin
      m_csr[12'(a)] = 0; m_wmask[12'(a)] = 0;
    end
    e_redir = 1'b0;
    e_rpc   = '0;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_csr[a] | 64'h1800;
      12'h301: return MISA_EXP;
      12'hF14: return 64'(HID);
      default: return m_csr[a];
    endcase
  endfunction

  function automatic void m_advance();
    logic [63:0] nxt [logic [11:0]];
    logic [63:0] st, cur, v;
    logic [11:0] wa;
    nxt = m_csr;
    st  = m_csr[12'h300];
    wa  = bus.waddr_i;
    nxt[12'hB00] = m_csr[12'hB00] + 64'd1;
    e_redir = 1'b0;
    if (!bus.stall_i) begin
      if (bus.instret_i) nxt[12'hB02] = m_csr[12'hB02] + 64'd1;
      if (bus.ecall_i) begin
        nxt[12'h341] = bus.pc_i & ~64'h3;
        nxt[12'h342] = 64'd11;
        nxt[12'h343] = 64'd0;
        nxt[12'h300] = st[3] ? 64'h80 : 64'h0;
        e_redir = 1'b1;
        e_rpc   = m_csr[12'h305];
      end else if (bus.mret_i) begin
        nxt[12'h300] = 64'h80 | (st[7] ? 64'h8 : 64'h0);
        e_redir = 1'b1;
        e_rpc   = m_csr[12'h341];
      end else if (bus.we_i && bus.wop_i != 2'b11 && m_csr.exists(wa) && wa[11:4] != 8'hF1) begin
        cur = m_read(wa);
        case (bus.wop_i)
          2'b00:   v = bus.wdata_i;
          2'b01:   v = cur | bus.wdata_i;
          default: v = cur & ~bus.wdata_i;
        endcase
        nxt[wa] = v & m_wmask[wa];
      end
    end
    m_csr = nxt;
  endfunction

  // Compare DUT against the model every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic [63:0] exp_rd;
    logic        exp_ill;
    logic [11:0] ra, wa;
    ra = bus.raddr_i;
    wa = bus.waddr_i;
    if (m_valid) begin
      exp_rd  = (bus.re_i && m_csr.exists(ra)) ? m_read(ra) : 64'd0;
      exp_ill = (bus.re_i && !m_csr.exists(ra)) ||
                (bus.we_i && (!m_csr.exists(wa) || wa[11:4] == 8'hF1));
      chk("redirect", 64'(bus.redirect_o), 64'(e_redir));
      chk("redirect_pc", bus.redirect_pc_o, e_rpc);
      chk("rdata", bus.rdata_o, exp_rd);
      chk("illegal", 64'(bus.illegal_o), 64'(exp_ill));
    end
    if (rst) begin
      m_reset();
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_advance();
    end
  end

  task automatic idle();
    bus.stall_i = 0; bus.re_i = 0; bus.raddr_i = 0; bus.we_i = 0; bus.waddr_i = 0;
    bus.wop_i = 0; bus.wdata_i = 0; bus.ecall_i = 0; bus.mret_i = 0; bus.pc_i = 0;
    bus.instret_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [11:0] a);
    bus.re_i = 1; bus.raddr_i = a;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] d);
    bus.we_i = 1; bus.waddr_i = a; bus.wop_i = op; bus.wdata_i = d;
  endtask

  logic [11:0] pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF12, 12'hF13,
                             12'hF14, 12'hF15, 12'h7C0, 12'h000, 12'hB01, 12'hF10};

  initial begin
    rst = 1;
    idle();
    repeat (3) cyc();
    rst = 0;

    cyc(); rd(12'h300); #1 chk("lit_mstatus_rst", bus.rdata_o, 64'h1800);
    cyc(); rd(12'h305); #1 chk("lit_mtvec_rst", bus.rdata_o, 64'h8000_0000);
    cyc(); rd(12'hF14); #1 chk("lit_mhartid", bus.rdata_o, 64'd3);

    cyc(); wr(12'h305, 2'b00, 64'h8000_0103);
    cyc(); rd(12'h305); #1 chk("lit_mtvec_align", bus.rdata_o, 64'h8000_0100);
    cyc(); wr(12'h300, 2'b01, 64'h8);
    cyc(); rd(12'h300); #1 chk("lit_mie_set", bus.rdata_o, 64'h1808);
    cyc(); wr(12'h300, 2'b10, 64'h8);
    cyc(); rd(12'h300); #1 chk("lit_mie_clr", bus.rdata_o, 64'h1800);

    cyc(); wr(12'h340, 2'b00, 64'h55);
    cyc(); wr(12'h300, 2'b01, 64'h8);
    cyc(); bus.ecall_i = 1; bus.pc_i = 64'h8000_0010; wr(12'h340, 2'b00, 64'hAA);
    cyc(); rd(12'h341);
    #1 chk("lit_ecall_redir", 64'(bus.redirect_o), 64'd1);
    chk("lit_ecall_rpc", bus.redirect_pc_o, 64'h8000_0100);
    chk("lit_mepc", bus.rdata_o, 64'h8000_0010);
    cyc(); rd(12'h342);
    #1 chk("lit_redir_pulse", 64'(bus.redirect_o), 64'd0);
    chk("lit_mcause", bus.rdata_o, 64'd11);
    cyc(); rd(12'h300); #1 chk("lit_mstatus_trap", bus.rdata_o, 64'h1880);
    cyc(); rd(12'h340); #1 chk("lit_mscratch_kept", bus.rdata_o, 64'h55);

    cyc(); wr(12'h341, 2'b00, 64'h8000_0014);
    cyc(); bus.mret_i = 1;
    cyc(); rd(12'h300);
    #1 chk("lit_mret_rpc", bus.redirect_pc_o, 64'h8000_0014);
    chk("lit_mret_redir", 64'(bus.redirect_o), 64'd1);
    chk("lit_mstatus_mret", bus.rdata_o, 64'h1888);

    cyc(); bus.stall_i = 1; bus.ecall_i = 1; bus.pc_i = 64'h1234;
    cyc(); rd(12'h341);
    #1 chk("lit_stall_noredir", 64'(bus.redirect_o), 64'd0);
    chk("lit_stall_mepc", bus.rdata_o, 64'h8000_0014);
    cyc(); rd(12'h300); #1 chk("lit_stall_mstatus", bus.rdata_o, 64'h1888);

    cyc(); wr(12'hB00, 2'b00, '1);
    cyc(); rd(12'hB00); #1 chk("lit_mcycle_ones", bus.rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(); rd(12'hB00); #1 chk("lit_mcycle_wrap", bus.rdata_o, 64'd0);

    cyc(); wr(12'hF14, 2'b00, 64'd7); #1 chk("lit_ill_wr_f14", 64'(bus.illegal_o), 64'd1);
    cyc(); rd(12'hF14); #1 chk("lit_f14_kept", bus.rdata_o, 64'd3);
    cyc(); rd(12'h7C0); #1 chk("lit_ill_rd_7c0", 64'(bus.illegal_o), 64'd1);

    cyc(); bus.ecall_i = 1; bus.pc_i = 64'h40; rst = 1;
    cyc(); rst = 0; rd(12'h305);
    #1 chk("lit_rst_cancel", 64'(bus.redirect_o), 64'd0);
    chk("lit_rst_mtvec", bus.rdata_o, 64'h8000_0000);

    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst           = ($urandom % 150) == 0;
      bus.stall_i   = ($urandom % 5) == 0;
      bus.re_i      = ($urandom % 4) != 0;
      bus.raddr_i   = pool[$urandom % 20];
      bus.we_i      = ($urandom % 3) == 0;
      bus.waddr_i   = pool[$urandom % 20];
      bus.wop_i     = 2'($urandom % 4);
      bus.wdata_i   = ($urandom % 4 == 0) ? 64'($urandom % 256) : {$urandom, $urandom};
      bus.ecall_i   = ($urandom % 15) == 0;
      bus.mret_i    = ($urandom % 15) == 0;
      bus.pc_i      = {$urandom, $urandom};
      bus.instret_i = ($urandom % 2) == 0;
    end

    cyc(); rst = 0;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR file with trap sequencing for the in-order RISC-V core. It holds the M-mode CSRs and performs read-modify-write CSR operations at the write-back stage. It also runs the free-running cycle and retired-instruction counters, and handles `ecall` trap entry and `mret` return with a registered PC redirect to the fetch stage.

## Interface
- `XLEN`, 64: register width; 32 or 64.
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RST`, 0: reset value of `mtvec`; bits [1:0] are forced to 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: pipeline hold; blocks all architectural updates except `mcycle`.
- `re_i` in 1: CSR read enable.
- `raddr_i` in 12: CSR read address.
- `rdata_o` out XLEN: combinational read data; 0 when `re_i`=0.
- `we_i` in 1: CSR write enable.
- `waddr_i` in 12: CSR write address.
- `wop_i` in 2: 00 write, 01 set (`csr|wdata`), 10 clear (`csr&~wdata`), 11 reserved (no write).
- `wdata_i` in XLEN: operand, either rs1 or the zero-extended uimm.
- `illegal_o` out 1: combinational; marks an unimplemented read/write address, or a write to the 0xF1x range.
- `ecall_i` in 1: `ecall` retiring this cycle.
- `mret_i` in 1: `mret` retiring this cycle.
- `pc_i` in XLEN: PC of the retiring instruction.
- `instret_i` in 1: an instruction retires this cycle.
- `redirect_o` out 1: one-cycle registered redirect pulse.
- `redirect_pc_o` out XLEN: redirect target; holds its value until the next redirect.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300: MIE bit 3 and MPIE bit 7 are RW. MPP [12:11] reads 2'b11. All other bits read 0.
  - `misa` 0x301: WARL, writes ignored. MXL is 2 (XLEN=64) or 1 (XLEN=32) in the top two bits; bit 8 (I) is set.
  - `mie` 0x304: bits 3, 7, 11 are RW; other bits 0.
  - `mtvec` 0x305: [1:0] read 0.
  - `mscratch` 0x340: full RW.
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342: full RW.
  - `mtval` 0x343: full RW.
  - `mip` 0x344: reads 0, writes ignored.
  - `mcycle` 0xB00 and `minstret` 0xB02: full RW.
  - 0xF11–0xF13 and 0xF15 read 0; `mhartid` 0xF14 reads `HART_ID`.
- Any other address asserts `illegal_o`, and a write to it is discarded.
- RMW: the new value is computed from the current register value, then masked by the per-CSR writable bits. `rdata_o` always shows the pre-write value.
- Trap entry on `ecall_i`:
  - `mepc` ← `pc_i`. No +4 is applied; the handler advances `mepc`.
  - `mcause` ← 11.
  - `mtval` ← 0.
  - MPIE ← MIE, then MIE ← 0.
  - Redirect target is `mtvec`.
- `mret_i`: MIE ← MPIE, MPIE ← 1; redirect target is `mepc`.
- Same-cycle priority is `ecall_i` > `mret_i` > CSR write. A CSR write in the same cycle as `ecall_i` or `mret_i` is discarded.
- Counters:
  - `mcycle` increments every cycle, including while stalled.
  - `minstret` increments when `instret_i` && !`stall_i`.
  - A CSR write to either counter overrides its increment in that cycle.
  - Both wrap from all-ones to 0.

## Timing
- Reset: all CSRs 0 except `mtvec`=`MTVEC_RST`. `redirect_o`=0 and `redirect_pc_o`=0.
- CSR writes, trap and mret updates, and `minstret` take effect at the rising edge when !`stall_i`.
- While `stall_i`=1:
  - No CSR write occurs.
  - `ecall_i` and `mret_i` are ignored; the pipeline re-presents them.
  - `redirect_o` stays 0.
- `redirect_o` is high exactly in cycle N+1 after `ecall_i` or `mret_i` is accepted in cycle N.
- `redirect_pc_o` reflects `mtvec`/`mepc` as they were in cycle N, before that edge's updates.
- Read-after-write: a read in cycle N+1 sees the value written in cycle N. There is no internal bypass within a cycle.
- `rst` asserted mid-trap cancels a pending `redirect_o` on the next edge.

## Test plan
- Reset, then read `mstatus`/`mtvec`/`mhartid` with `HART_ID`=3, `MTVEC_RST`=0x8000_0000 → 0x1800 / 0x8000_0000 / 3.
- Write `mtvec`=0x8000_0103, then set `mstatus` with 0x8, then clear with 0x8 → `mtvec` reads 0x8000_0100; MIE reads 1, then 0.
- MIE=1, `ecall_i` with `pc_i`=0x8000_0010 → next cycle `redirect_o`=1 and `redirect_pc_o`=`mtvec`; `mepc`=0x8000_0010, `mcause`=11, MIE=0, MPIE=1.
- `mret_i` after handler wrote `mepc`=0x8000_0014 → `redirect_pc_o`=0x8000_0014, MIE=1, MPIE=1.
- `ecall_i` and a `mscratch` write in the same cycle → `mscratch` unchanged. `ecall_i` with `stall_i`=1 → no redirect and no CSR change.
- Write `mcycle`=all-ones → reads 0 two cycles later. Write to 0xF14 or read of 0x7C0 → `illegal_o`=1, state unchanged.
